// File: rtl/sample_circuit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_circuit_pkg
// Purpose  : Shared types and constants for the sample_circuit BIST engine.
//            - bist_state_e : sweep controller states
//            - N_IN_DEF     : default number of circuit inputs
//            - SETTLE_W     : width of the settle-interval counter
// Revision : 1.0 - initial release
// ============================================================================
package sample_circuit_pkg;

  localparam int N_IN_DEF = 5;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } bist_state_e;

endpackage : sample_circuit_pkg
`default_nettype wire

// File: rtl/bist_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : bist_settle_timer
// Purpose  : Counts cycles a stimulus vector has been held and flags the last
//            cycle of the settle interval.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            i_clear    - synchronous clear of the count (wins over enable)
//            i_enable   - advance the count by one this cycle
//            o_expired  - high while enabled and count == SETTLE_CYCLES-1
// Revision : 1.0 - initial release
// ============================================================================
module bist_settle_timer
  import sample_circuit_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [SETTLE_W-1:0] c_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [SETTLE_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + SETTLE_W'(1);
    end
  end

  assign o_expired = i_enable && (r_cnt == c_LAST);

endmodule : bist_settle_timer
`default_nettype wire

// File: rtl/sample_circuit_bist.sv
`default_nettype none
// ============================================================================
// Module   : sample_circuit_bist
// Purpose  : Self-test engine for the 5-input/1-output sample_circuit. Sweeps
//            every input vector, holds each for SETTLE_CYCLES cycles, samples
//            Y for one cycle and compares it with the EXP_TT truth table.
// Ports    : clk            - system clock, rising edge
//            rst_n          - asynchronous active-low reset
//            start          - level, launches a sweep from IDLE/DONE
//            abort          - synchronous abort of a running sweep
//            vec            - {A,B,C,D,E} drive to circuit under test
//            y_in           - Y from circuit under test
//            busy           - sweep in progress (APPLY/SAMPLE)
//            done           - sweep completed, held until next start
//            pass           - valid with done, 1 when no mismatches
//            err_cnt        - mismatch count of last/current sweep
//            first_fail_idx - first mismatching vector, 0 if none
//            fail_seen      - sticky mismatch flag for this sweep
// Revision : 1.0 - initial release
// ============================================================================
module sample_circuit_bist
  import sample_circuit_pkg::*;
#(
  parameter int                        N_IN          = N_IN_DEF,
  parameter int                        SETTLE_CYCLES = 2,
  parameter logic [(2**N_IN)-1:0]      EXP_TT        = 32'hA5A5_A5A5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            fail_seen
);

  bist_state_e     r_state;
  bist_state_e     w_state_nxt;

  logic [N_IN-1:0] r_idx;
  logic [N_IN-1:0] r_vec;
  logic            r_done;
  logic            r_pass;
  logic [N_IN:0]   r_err_cnt;
  logic [N_IN-1:0] r_ffi;
  logic            r_fail_seen;

  logic            w_idle_or_done;
  logic            w_busy;
  logic            w_launch;
  logic            w_abort;
  logic            w_expired;
  logic            w_last;
  logic            w_mismatch;
  logic [N_IN:0]   w_err_nxt;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_busy         = (r_state == S_APPLY) || (r_state == S_SAMPLE);
  assign w_launch       = w_idle_or_done && start;
  assign w_abort        = w_busy && abort;
  assign w_last         = &r_idx;

  // Y is captured only on the edge that leaves SAMPLE, so anything y_in does
  // while the vector is still settling never reaches the comparator. An
  // aborted SAMPLE cycle is not scored.
  assign w_mismatch = (r_state == S_SAMPLE) && !abort && (y_in != EXP_TT[r_idx]);
  assign w_err_nxt  = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

  // The count restarts from zero on every entry into APPLY.
  bist_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state != S_APPLY),
    .i_enable  (r_state == S_APPLY),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        if (abort)          w_state_nxt = S_IDLE;
        else if (w_expired) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)       w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
        else             w_state_nxt = S_APPLY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_vec       <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_ffi       <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_launch) begin
      r_idx       <= '0;
      r_vec       <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_ffi       <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_abort) begin
      // Partial error statistics are kept for post-mortem inspection.
      r_idx  <= '0;
      r_vec  <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (r_state == S_SAMPLE) begin
      r_err_cnt <= w_err_nxt;
      if (w_mismatch && !r_fail_seen) begin
        r_ffi       <= r_idx;
        r_fail_seen <= 1'b1;
      end
      if (w_last) begin
        // vec stays on the final vector while results are presented.
        r_done <= 1'b1;
        r_pass <= (w_err_nxt == '0);
      end else begin
        r_idx <= r_idx + N_IN'(1);
        r_vec <= r_idx + N_IN'(1);
      end
    end
  end

  assign vec            = r_vec;
  assign busy           = w_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_fail_idx = r_ffi;
  assign fail_seen      = r_fail_seen;

endmodule : sample_circuit_bist
`default_nettype wire
